ocra_grad_ctrl: RTL and testbench

OCRA_GRAD_CTRL -- requirements
Module: ocra_grad_ctrl

---
 rtl/ocra_grad_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 tb/tb_ocra_grad_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ocra_grad_ctrl.sv
// OCRA1 / GPA-FHDO gradient DAC serial controller with AXI4-Lite register
// access and a level interrupt signalling end of transfer.
module ocra_grad_ctrl #(
    parameter integer      C_S00_AXI_DATA_WIDTH    = 32,
    parameter integer      C_S00_AXI_ADDR_WIDTH    = 14,
    parameter integer      C_S_AXI_INTR_DATA_WIDTH = 32,
    parameter integer      C_S_AXI_INTR_ADDR_WIDTH = 5,
    parameter integer      C_NUM_OF_INTR           = 1,
    parameter logic [31:0] C_INTR_SENSITIVITY      = 32'hffffffff,
    parameter logic [31:0] C_INTR_ACTIVE_STATE     = 32'hffffffff,
    parameter integer      C_IRQ_SENSITIVITY       = 1,
    parameter integer      C_IRQ_ACTIVE_STATE      = 1
) (
    input  logic                                   s00_axi_aclk,
    input  logic                                   s00_axi_aresetn,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]        s00_axi_awaddr,
    input  logic [2:0]                             s00_axi_awprot,
    input  logic                                   s00_axi_awvalid,
    output logic                                   s00_axi_awready,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]        s00_axi_wdata,
    input  logic [(C_S00_AXI_DATA_WIDTH/8)-1:0]    s00_axi_wstrb,
    input  logic                                   s00_axi_wvalid,
    output logic                                   s00_axi_wready,
    output logic [1:0]                             s00_axi_bresp,
    output logic                                   s00_axi_bvalid,
    input  logic                                   s00_axi_bready,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]        s00_axi_araddr,
    input  logic [2:0]                             s00_axi_arprot,
    input  logic                                   s00_axi_arvalid,
    output logic                                   s00_axi_arready,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]        s00_axi_rdata,
    output logic [1:0]                             s00_axi_rresp,
    output logic                                   s00_axi_rvalid,
    input  logic                                   s00_axi_rready,
    input  logic                                   s_axi_intr_aclk,
    input  logic                                   s_axi_intr_aresetn,
    input  logic [C_S_AXI_INTR_ADDR_WIDTH-1:0]     s_axi_intr_awaddr,
    input  logic [2:0]                             s_axi_intr_awprot,
    input  logic                                   s_axi_intr_awvalid,
    output logic                                   s_axi_intr_awready,
    input  logic [C_S_AXI_INTR_DATA_WIDTH-1:0]     s_axi_intr_wdata,
    input  logic [(C_S_AXI_INTR_DATA_WIDTH/8)-1:0] s_axi_intr_wstrb,
    input  logic                                   s_axi_intr_wvalid,
    output logic                                   s_axi_intr_wready,
    output logic [1:0]                             s_axi_intr_bresp,
    output logic                                   s_axi_intr_bvalid,
    input  logic                                   s_axi_intr_bready,
    input  logic [C_S_AXI_INTR_ADDR_WIDTH-1:0]     s_axi_intr_araddr,
    input  logic [2:0]                             s_axi_intr_arprot,
    input  logic                                   s_axi_intr_arvalid,
    output logic                                   s_axi_intr_arready,
    output logic [C_S_AXI_INTR_DATA_WIDTH-1:0]     s_axi_intr_rdata,
    output logic [1:0]                             s_axi_intr_rresp,
    output logic                                   s_axi_intr_rvalid,
    input  logic                                   s_axi_intr_rready,
    output logic                                   irq,
    input  logic [13:0]                            grad_bram_offset_i,
    input  logic                                   grad_bram_rst_i,
    output logic                                   oc1_clk_o,
    output logic                                   oc1_syncn_o,
    output logic                                   oc1_ldacn_o,
    output logic                                   oc1_sdox_o,
    output logic                                   oc1_sdoy_o,
    output logic                                   oc1_sdoz_o,
    output logic                                   oc1_sdoz2_o,
    output logic                                   fhd_clk_o,
    output logic                                   fhd_sdo_o,
    output logic                                   fhd_ssn_o,
    input  logic                                   fhd_sdi_i
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LDAC} state_t;

    logic        aw_rdy, b_vld, ar_rdy, r_vld, wr_en, rd_en, start;
    logic [31:0] r_data, rd_mux;
    logic [11:0] wr_idx, rd_idx;
    logic [31:0] ctrl, fhd_rx, sr_f;
    logic [3:0]  div, hcnt;
    logic [23:0] data_x, data_y, data_z, data_z2, sr_x, sr_y, sr_z, sr_z2;
    logic        busy, mode, sclk;
    logic [4:0]  bitcnt, last_bit;
    state_t      state;
    logic        i_aw_rdy, i_b_vld, i_ar_rdy, i_r_vld, i_wr_en, i_rd_en;
    logic [31:0] i_r_data;
    logic        gie, ier, isr, busy_q;
    logic        unused_ok;

    function automatic logic [31:0] apply_strb(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int unsigned i = 0; i < 4; i++)
            if (st[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    assign wr_en    = aw_rdy & s00_axi_awvalid & s00_axi_wvalid;
    assign rd_en    = ar_rdy & s00_axi_arvalid;
    assign wr_idx   = s00_axi_awaddr[13:2];
    assign rd_idx   = s00_axi_araddr[13:2];
    assign start    = wr_en && (wr_idx == 12'd3) && !busy && !grad_bram_rst_i;
    assign last_bit = mode ? 5'd31 : 5'd23;

    assign s00_axi_awready = aw_rdy;
    assign s00_axi_wready  = aw_rdy;
    assign s00_axi_bvalid  = b_vld;
    assign s00_axi_bresp   = 2'b00;
    assign s00_axi_arready = ar_rdy;
    assign s00_axi_rvalid  = r_vld;
    assign s00_axi_rdata   = r_data;
    assign s00_axi_rresp   = 2'b00;

    // Main bus handshake: address and data accepted together, one-cycle ready pulses
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            aw_rdy <= 1'b0;
            b_vld  <= 1'b0;
            ar_rdy <= 1'b0;
            r_vld  <= 1'b0;
            r_data <= '0;
        end else begin
            aw_rdy <= !aw_rdy && s00_axi_awvalid && s00_axi_wvalid && !b_vld;
            if (wr_en) b_vld <= 1'b1;
            else if (s00_axi_bready) b_vld <= 1'b0;
            ar_rdy <= !ar_rdy && s00_axi_arvalid && !r_vld;
            if (rd_en) begin
                r_vld  <= 1'b1;
                r_data <= rd_mux;
            end else if (s00_axi_rready) begin
                r_vld <= 1'b0;
            end
        end
    end

    // Main bus read decode
    always_comb begin
        rd_mux = '0;
        case (rd_idx)
            12'd0:   rd_mux = ctrl;
            12'd1:   rd_mux = {28'd0, div};
            12'd2:   rd_mux = {2'b00, grad_bram_offset_i, 15'd0, busy};
            12'd4:   rd_mux = {8'd0, data_x};
            12'd5:   rd_mux = {8'd0, data_y};
            12'd6:   rd_mux = {8'd0, data_z};
            12'd7:   rd_mux = {8'd0, data_z2};
            12'd8:   rd_mux = fhd_rx;
            default: rd_mux = '0;
        endcase
    end

    // Main bus register file with byte strobes
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            ctrl    <= '0;
            div     <= '0;
            data_x  <= '0;
            data_y  <= '0;
            data_z  <= '0;
            data_z2 <= '0;
        end else if (wr_en) begin
            case (wr_idx)
                12'd0:   ctrl    <= apply_strb(ctrl, s00_axi_wdata, s00_axi_wstrb);
                12'd1:   if (s00_axi_wstrb[0]) div <= s00_axi_wdata[3:0];
                12'd4:   data_x  <= 24'(apply_strb({8'd0, data_x}, s00_axi_wdata, s00_axi_wstrb));
                12'd5:   data_y  <= 24'(apply_strb({8'd0, data_y}, s00_axi_wdata, s00_axi_wstrb));
                12'd6:   data_z  <= 24'(apply_strb({8'd0, data_z}, s00_axi_wdata, s00_axi_wstrb));
                12'd7:   data_z2 <= 24'(apply_strb({8'd0, data_z2}, s00_axi_wdata, s00_axi_wstrb));
                default: ;
            endcase
        end
    end

    // Serial engine: data changes on the falling serial clock, FHDO input sampled on the rising one
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state <= S_IDLE;
            busy <= 1'b0; mode <= 1'b0; sclk <= 1'b0;
            hcnt <= '0; bitcnt <= '0;
            sr_x <= '0; sr_y <= '0; sr_z <= '0; sr_z2 <= '0; sr_f <= '0;
            fhd_rx <= '0;
            oc1_clk_o <= 1'b0; oc1_syncn_o <= 1'b1; oc1_ldacn_o <= 1'b1;
            oc1_sdox_o <= 1'b0; oc1_sdoy_o <= 1'b0; oc1_sdoz_o <= 1'b0; oc1_sdoz2_o <= 1'b0;
            fhd_clk_o <= 1'b0; fhd_sdo_o <= 1'b0; fhd_ssn_o <= 1'b1;
        end else if (grad_bram_rst_i) begin
            state <= S_IDLE;
            busy <= 1'b0; sclk <= 1'b0; hcnt <= '0; bitcnt <= '0;
            oc1_clk_o <= 1'b0; oc1_syncn_o <= 1'b1; oc1_ldacn_o <= 1'b1;
            oc1_sdox_o <= 1'b0; oc1_sdoy_o <= 1'b0; oc1_sdoz_o <= 1'b0; oc1_sdoz2_o <= 1'b0;
            fhd_clk_o <= 1'b0; fhd_sdo_o <= 1'b0; fhd_ssn_o <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy <= 1'b1; mode <= ctrl[0]; sclk <= 1'b0;
                        hcnt <= '0; bitcnt <= '0;
                        state <= S_SHIFT;
                        if (ctrl[0]) begin
                            sr_f <= s00_axi_wdata;
                            fhd_sdo_o <= s00_axi_wdata[31];
                            fhd_ssn_o <= 1'b0;
                        end else begin
                            sr_x <= data_x; sr_y <= data_y; sr_z <= data_z; sr_z2 <= data_z2;
                            oc1_sdox_o <= data_x[23]; oc1_sdoy_o <= data_y[23];
                            oc1_sdoz_o <= data_z[23]; oc1_sdoz2_o <= data_z2[23];
                            oc1_syncn_o <= 1'b0;
                        end
                    end
                end
                S_SHIFT: begin
                    if (hcnt != div) begin
                        hcnt <= hcnt + 4'd1;
                    end else begin
                        hcnt <= '0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                            if (mode) begin
                                fhd_clk_o <= 1'b1;
                                fhd_rx <= {fhd_rx[30:0], fhd_sdi_i};
                            end else begin
                                oc1_clk_o <= 1'b1;
                            end
                        end else begin
                            sclk <= 1'b0;
                            oc1_clk_o <= 1'b0;
                            fhd_clk_o <= 1'b0;
                            sr_x <= {sr_x[22:0], 1'b0}; sr_y <= {sr_y[22:0], 1'b0};
                            sr_z <= {sr_z[22:0], 1'b0}; sr_z2 <= {sr_z2[22:0], 1'b0};
                            sr_f <= {sr_f[30:0], 1'b0};
                            if (bitcnt == last_bit) begin
                                oc1_sdox_o <= 1'b0; oc1_sdoy_o <= 1'b0;
                                oc1_sdoz_o <= 1'b0; oc1_sdoz2_o <= 1'b0;
                                fhd_sdo_o <= 1'b0;
                                if (mode) begin
                                    fhd_ssn_o <= 1'b1;
                                    busy <= 1'b0;
                                    state <= S_IDLE;
                                end else begin
                                    oc1_syncn_o <= 1'b1;
                                    oc1_ldacn_o <= 1'b0;
                                    state <= S_LDAC;
                                end
                            end else begin
                                bitcnt <= bitcnt + 5'd1;
                                if (mode) begin
                                    fhd_sdo_o <= sr_f[30];
                                end else begin
                                    oc1_sdox_o <= sr_x[22]; oc1_sdoy_o <= sr_y[22];
                                    oc1_sdoz_o <= sr_z[22]; oc1_sdoz2_o <= sr_z2[22];
                                end
                            end
                        end
                    end
                end
                S_LDAC: begin
                    if (hcnt != div) begin
                        hcnt <= hcnt + 4'd1;
                    end else begin
                        hcnt <= '0;
                        oc1_ldacn_o <= 1'b1;
                        busy <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign i_wr_en = i_aw_rdy & s_axi_intr_awvalid & s_axi_intr_wvalid;
    assign i_rd_en = i_ar_rdy & s_axi_intr_arvalid;

    assign s_axi_intr_awready = i_aw_rdy;
    assign s_axi_intr_wready  = i_aw_rdy;
    assign s_axi_intr_bvalid  = i_b_vld;
    assign s_axi_intr_bresp   = 2'b00;
    assign s_axi_intr_arready = i_ar_rdy;
    assign s_axi_intr_rvalid  = i_r_vld;
    assign s_axi_intr_rdata   = i_r_data;
    assign s_axi_intr_rresp   = 2'b00;
    assign irq = gie & ier & isr;

    // Interrupt bus and registers; the intr clock is the main clock, so one domain is used
    always_ff @(posedge s00_axi_aclk or negedge s_axi_intr_aresetn) begin
        if (!s_axi_intr_aresetn) begin
            i_aw_rdy <= 1'b0; i_b_vld <= 1'b0; i_ar_rdy <= 1'b0; i_r_vld <= 1'b0;
            i_r_data <= '0;
            gie <= 1'b0; ier <= 1'b0; isr <= 1'b0; busy_q <= 1'b0;
        end else begin
            busy_q <= busy;
            i_aw_rdy <= !i_aw_rdy && s_axi_intr_awvalid && s_axi_intr_wvalid && !i_b_vld;
            if (i_wr_en) i_b_vld <= 1'b1;
            else if (s_axi_intr_bready) i_b_vld <= 1'b0;
            i_ar_rdy <= !i_ar_rdy && s_axi_intr_arvalid && !i_r_vld;
            if (i_rd_en) begin
                i_r_vld <= 1'b1;
                case (s_axi_intr_araddr[4:2])
                    3'd0:    i_r_data <= {31'd0, gie};
                    3'd1:    i_r_data <= {31'd0, ier};
                    3'd2:    i_r_data <= {31'd0, isr};
                    default: i_r_data <= '0;
                endcase
            end else if (s_axi_intr_rready) begin
                i_r_vld <= 1'b0;
            end
            if (i_wr_en && s_axi_intr_wstrb[0]) begin
                if (s_axi_intr_awaddr[4:2] == 3'd0) gie <= s_axi_intr_wdata[0];
                if (s_axi_intr_awaddr[4:2] == 3'd1) ier <= s_axi_intr_wdata[0];
            end
            if (busy_q && !busy) isr <= 1'b1;
            else if (i_wr_en && s_axi_intr_wstrb[0] && s_axi_intr_wdata[0]
                     && s_axi_intr_awaddr[4:2] == 3'd3) isr <= 1'b0;
        end
    end

    assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0],
                         s_axi_intr_aclk, s_axi_intr_awprot, s_axi_intr_arprot,
                         s_axi_intr_awaddr[1:0], s_axi_intr_araddr[1:0],
                         s_axi_intr_wdata[31:1], s_axi_intr_wstrb[3:1],
                         C_NUM_OF_INTR[0], C_INTR_SENSITIVITY[0], C_INTR_ACTIVE_STATE[0],
                         C_IRQ_SENSITIVITY[0], C_IRQ_ACTIVE_STATE[0]};

endmodule

// File: tb/tb_ocra_grad_ctrl.sv
// Directed bench for ocra_grad_ctrl: register access, both serial modes,
// abort and interrupt behaviour.
module tb_ocra_grad_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, irst_n;
    logic [13:0] awaddr, araddr;
    logic [2:0]  awprot, arprot, i_awprot, i_arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata, i_wdata, i_rdata;
    logic [3:0]  wstrb, i_wstrb;
    logic [1:0]  bresp, rresp, i_bresp, i_rresp;
    logic [4:0]  i_awaddr, i_araddr;
    logic        i_awvalid, i_awready, i_wvalid, i_wready, i_bvalid, i_bready;
    logic        i_arvalid, i_arready, i_rvalid, i_rready;
    logic        irq;
    logic [13:0] offset;
    logic        grad_rst;
    logic        oc1_clk, syncn, ldacn, sdox, sdoy, sdoz, sdoz2;
    logic        fhd_clk, fhd_sdo, fhd_ssn, fhd_sdi;

    int          vectors = 0;
    int          miscompares = 0;
    int          aw_samples, aw_both, oc_rises, fhd_rises, sync_lo, ldac_lo, ssn_lo;
    logic [1:0]  last_bresp;
    logic [23:0] ox_word, oy_word;
    logic [31:0] fhd_word, rd, isr_val;
    logic [1:0]  rsp;

    always #5 clk = ~clk;

    ocra_grad_ctrl #(.C_S00_AXI_DATA_WIDTH(32), .C_S00_AXI_ADDR_WIDTH(14)) dut (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
        .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
        .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
        .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
        .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
        .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
        .s00_axi_rready(rready),
        .s_axi_intr_aclk(clk), .s_axi_intr_aresetn(irst_n),
        .s_axi_intr_awaddr(i_awaddr), .s_axi_intr_awprot(i_awprot),
        .s_axi_intr_awvalid(i_awvalid), .s_axi_intr_awready(i_awready),
        .s_axi_intr_wdata(i_wdata), .s_axi_intr_wstrb(i_wstrb),
        .s_axi_intr_wvalid(i_wvalid), .s_axi_intr_wready(i_wready),
        .s_axi_intr_bresp(i_bresp), .s_axi_intr_bvalid(i_bvalid),
        .s_axi_intr_bready(i_bready), .s_axi_intr_araddr(i_araddr),
        .s_axi_intr_arprot(i_arprot), .s_axi_intr_arvalid(i_arvalid),
        .s_axi_intr_arready(i_arready), .s_axi_intr_rdata(i_rdata),
        .s_axi_intr_rresp(i_rresp), .s_axi_intr_rvalid(i_rvalid),
        .s_axi_intr_rready(i_rready), .irq(irq),
        .grad_bram_offset_i(offset), .grad_bram_rst_i(grad_rst),
        .oc1_clk_o(oc1_clk), .oc1_syncn_o(syncn), .oc1_ldacn_o(ldacn),
        .oc1_sdox_o(sdox), .oc1_sdoy_o(sdoy), .oc1_sdoz_o(sdoz), .oc1_sdoz2_o(sdoz2),
        .fhd_clk_o(fhd_clk), .fhd_sdo_o(fhd_sdo), .fhd_ssn_o(fhd_ssn), .fhd_sdi_i(fhd_sdi)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ib selects the interrupt bus; returns on the negedge that first shows bvalid
    task automatic bus_write(input bit ib, input logic [13:0] a, input logic [31:0] d,
                             input logic [3:0] s);
        bit got = 1'b0;
        aw_samples = 0;
        aw_both = 0;
        if (ib) begin
            i_awaddr = a[4:0]; i_wdata = d; i_wstrb = s;
            i_awvalid = 1'b1; i_wvalid = 1'b1; i_bready = 1'b1;
        end else begin
            awaddr = a; wdata = d; wstrb = s;
            awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (ib ? i_awready : awready) begin
                aw_samples++;
                if (ib ? i_wready : wready) aw_both++;
            end
            if (ib ? i_bvalid : bvalid) begin
                got = 1'b1;
                last_bresp = ib ? i_bresp : bresp;
            end
        end
        awvalid = 1'b0; wvalid = 1'b0; i_awvalid = 1'b0; i_wvalid = 1'b0;
        if (!got) check("write_timeout", 32'(got), 32'd1);
    endtask

    task automatic bus_read(input bit ib, input logic [13:0] a, output logic [31:0] d,
                            output logic [1:0] r);
        bit got = 1'b0;
        d = 'x;
        r = 'x;
        if (ib) begin
            i_araddr = a[4:0]; i_arvalid = 1'b1; i_rready = 1'b1;
        end else begin
            araddr = a; arvalid = 1'b1; rready = 1'b1;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (ib ? i_rvalid : rvalid) begin
                got = 1'b1;
                d = ib ? i_rdata : rdata;
                r = ib ? i_rresp : rresp;
            end
        end
        arvalid = 1'b0; i_arvalid = 1'b0;
        if (!got) check("read_timeout", 32'(got), 32'd1);
    endtask

    // Samples serial pins once per cycle, capturing data at each rising serial clock
    task automatic monitor(input int cycles);
        logic prev_oc = 1'b0;
        logic prev_fc = 1'b0;
        oc_rises = 0; fhd_rises = 0; sync_lo = 0; ldac_lo = 0; ssn_lo = 0;
        ox_word = '0; oy_word = '0; fhd_word = '0;
        for (int i = 0; i < cycles; i++) begin
            if (oc1_clk && !prev_oc) begin
                oc_rises++;
                ox_word = {ox_word[22:0], sdox};
                oy_word = {oy_word[22:0], sdoy};
            end
            if (fhd_clk && !prev_fc) begin
                fhd_rises++;
                fhd_word = {fhd_word[30:0], fhd_sdo};
            end
            prev_oc = oc1_clk;
            prev_fc = fhd_clk;
            if (!syncn) sync_lo++;
            if (!ldacn) ldac_lo++;
            if (!fhd_ssn) ssn_lo++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; irst_n = 1'b0;
        awaddr = '0; araddr = '0; awprot = 3'b111; arprot = 3'b111;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        wdata = '0; wstrb = '0;
        i_awaddr = '0; i_araddr = '0; i_awprot = '0; i_arprot = '0;
        i_awvalid = 1'b0; i_wvalid = 1'b0; i_bready = 1'b0; i_arvalid = 1'b0; i_rready = 1'b0;
        i_wdata = '0; i_wstrb = '0;
        offset = '0; grad_rst = 1'b0; fhd_sdi = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_bus", 32'({awready, wready, bvalid, arready, rvalid, i_bvalid, i_rvalid}), 32'd0);
        check("rst_serial", 32'({oc1_clk, syncn, ldacn, sdox, sdoy, sdoz, sdoz2, fhd_clk, fhd_sdo, fhd_ssn}),
              32'b0110000001);
        check("rst_irq", 32'(irq), 32'd0);
        rst_n = 1'b1; irst_n = 1'b1;
        @(negedge clk);

        bus_write(1'b0, 14'h00, 32'hdeadbeef, 4'hf);
        check("wr_ready_cycles", 32'(aw_samples), 32'd1);
        check("wr_ready_both", 32'(aw_both), 32'd1);
        check("wr_bresp", 32'(last_bresp), 32'd0);
        bus_read(1'b0, 14'h00, rd, rsp);
        check("rd_ctrl", rd, 32'hdeadbeef);
        check("rd_rresp", 32'(rsp), 32'd0);

        bus_write(1'b0, 14'h14, 32'hffffffff, 4'b0010);
        bus_read(1'b0, 14'h14, rd, rsp);
        check("rd_data_y_strb", rd, 32'h0000ff00);
        bus_write(1'b0, 14'h04, 32'hffffffff, 4'hf);
        bus_read(1'b0, 14'h04, rd, rsp);
        check("rd_div_mask", rd, 32'h0000000f);
        bus_write(1'b0, 14'h40, 32'h12345678, 4'hf);
        bus_read(1'b0, 14'h40, rd, rsp);
        check("rd_unmapped", rd, 32'h0);

        bus_write(1'b0, 14'h04, 32'h0, 4'hf);
        bus_write(1'b0, 14'h00, 32'h0, 4'hf);
        bus_write(1'b0, 14'h10, 32'h00a5a5a5, 4'hf);
        bus_write(1'b0, 14'h0c, 32'h0, 4'hf);
        monitor(70);
        check("oc1_clk_periods", 32'(oc_rises), 32'd24);
        check("oc1_sdox_word", 32'(ox_word), 32'h00a5a5a5);
        check("oc1_sdoy_word", 32'(oy_word), 32'h0000ff00);
        check("oc1_syncn_low", 32'(sync_lo), 32'd48);
        check("oc1_ldacn_low", 32'(ldac_lo), 32'd1);
        check("oc1_fhd_idle", 32'({fhd_rises, ssn_lo}), 32'd0);
        bus_read(1'b0, 14'h08, rd, rsp);
        check("oc1_status_done", rd, 32'h0);

        bus_write(1'b0, 14'h00, 32'h1, 4'hf);
        fhd_sdi = 1'b1;
        bus_write(1'b0, 14'h0c, 32'h12345678, 4'hf);
        monitor(80);
        check("fhd_clk_periods", 32'(fhd_rises), 32'd32);
        check("fhd_sdo_word", fhd_word, 32'h12345678);
        check("fhd_ssn_low", 32'(ssn_lo), 32'd64);
        check("fhd_oc1_idle", 32'({oc_rises, sync_lo, ldac_lo}), 32'd0);
        bus_read(1'b0, 14'h20, rd, rsp);
        check("fhd_rx", rd, 32'hffffffff);

        offset = 14'h1abc;
        bus_read(1'b0, 14'h08, rd, rsp);
        check("status_offset", rd, 32'h1abc0000);
        grad_rst = 1'b1;
        bus_write(1'b0, 14'h0c, 32'hffffffff, 4'hf);
        @(negedge clk);
        check("trig_in_abort_ssn", 32'(fhd_ssn), 32'd1);
        bus_read(1'b0, 14'h08, rd, rsp);
        check("trig_in_abort_busy", rd, 32'h1abc0000);
        grad_rst = 1'b0;

        bus_write(1'b1, 14'h00, 32'h1, 4'hf);
        bus_write(1'b1, 14'h04, 32'h1, 4'hf);
        bus_write(1'b1, 14'h0c, 32'h1, 4'hf);
        check("irq_cleared_pre", 32'(irq), 32'd0);
        bus_write(1'b0, 14'h00, 32'h0, 4'hf);
        bus_write(1'b0, 14'h0c, 32'h0, 4'hf);
        repeat (60) @(negedge clk);
        check("irq_after_xfer", 32'(irq), 32'd1);
        bus_read(1'b1, 14'h08, isr_val, rsp);
        check("isr_after_xfer", isr_val, 32'h1);
        bus_write(1'b1, 14'h0c, 32'h1, 4'hf);
        check("irq_after_iar", 32'(irq), 32'd0);

        bus_write(1'b0, 14'h04, 32'h3, 4'hf);
        bus_write(1'b0, 14'h0c, 32'h0, 4'hf);
        repeat (20) @(negedge clk);
        check("abort_mid_syncn", 32'(syncn), 32'd0);
        grad_rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_outputs_idle", 32'({oc1_clk, syncn, ldacn, sdox, sdoy, sdoz, sdoz2}), 32'b0110000);
        @(negedge clk);
        grad_rst = 1'b0;
        bus_read(1'b0, 14'h08, rd, rsp);
        check("abort_busy", rd, 32'h1abc0000);
        bus_read(1'b1, 14'h08, isr_val, rsp);
        check("abort_isr", isr_val, 32'h1);
        check("abort_irq", 32'(irq), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
